pwm_capture: RTL and testbench

- Receive-side counterpart to the speed-programmable PWM generator.
- Samples an external PWM waveform and measures its period and high time in clk cycles.
- Publishes each completed rising-to-rising measurement with a one-cycle valid strobe.
- Flags loss of signal (line stuck high or low).
- Sits beside the PWM generator under the TinyTapeout top. pwm_in comes from a ui_in pin; results go to uo_out/uio_out muxing logic.

---
 rtl/pwm_capture_if.sv | 14 +
 rtl/pwm_capture.sv | 132 +++++++++++++
 tb/tb_pwm_capture.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: control, line input and measurement results of pwm_capture.
interface pwm_capture_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             pwm_in;
    logic             pwm_level;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             timeout;
    modport master (output enable, pwm_in, input pwm_level, period, high_time, meas_valid, timeout);
    modport slave (input enable, pwm_in, output pwm_level, period, high_time, meas_valid, timeout);
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM line, flags loss of signal.
// Optional glitch filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int               CNT_W      = 16,
    parameter logic [CNT_W-1:0] TIMEOUT    = 16'd50000,
    parameter int               GLITCH_LEN = 3
) (
    input logic          clk,
    input logic          rst_n,
    pwm_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t           r_state, w_state_nxt;
    logic             r_sync1, r_sync2, r_lvl_d;
    logic             w_lvl, w_rise, w_fall, w_pub, w_to;
    logic [CNT_W-1:0] r_cnt_per, r_cnt_hi, r_age;
    logic [CNT_W-1:0] w_per_nxt, w_hi_nxt, w_age_nxt, w_per_inc, w_hi_inc;
    logic [CNT_W-1:0] r_period, r_high;
    logic             r_valid, r_timeout;

    if (GLITCH_LEN < 2 || GLITCH_LEN > 15 || TIMEOUT < 2) begin : g_bad_param
        $error("pwm_capture: parameter out of range");
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic       r_filt;
    logic [3:0] r_run;
    // level flips only after GLITCH_LEN consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_run  <= '0;
        end else if (r_sync2 == r_filt) begin
            r_run <= '0;
        end else if (r_run == 4'(GLITCH_LEN - 1)) begin
            r_filt <= r_sync2;
            r_run  <= '0;
        end else begin
            r_run <= r_run + 4'd1;
        end
    end
    assign w_lvl = r_filt;
`else
    assign w_lvl = r_sync2;
`endif

    assign w_rise    = w_lvl & ~r_lvl_d;
    assign w_fall    = ~w_lvl & r_lvl_d;
    assign w_per_inc = &r_cnt_per ? r_cnt_per : r_cnt_per + 1'b1;
    assign w_hi_inc  = &r_cnt_hi ? r_cnt_hi : r_cnt_hi + 1'b1;
    assign w_age_nxt = (!bus.enable || w_rise || w_fall) ? '0
                     : (r_age == TIMEOUT) ? r_age : r_age + 1'b1;
    assign w_to      = bus.enable && (w_age_nxt == TIMEOUT);

    always_comb begin
        w_state_nxt = r_state;
        w_per_nxt   = w_per_inc;
        w_hi_nxt    = r_cnt_hi;
        w_pub       = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_state_nxt = w_rise ? HIGH : IDLE;
                w_per_nxt   = {{(CNT_W-1){1'b0}}, w_rise};
                w_hi_nxt    = {{(CNT_W-1){1'b0}}, w_rise};
            end
            HIGH: begin
                w_state_nxt = w_fall ? LOW : HIGH;
                w_hi_nxt    = w_fall ? r_cnt_hi : w_hi_inc;
            end
            LOW: begin
                if (w_rise) begin
                    w_pub       = 1'b1;
                    w_state_nxt = HIGH;
                    w_per_nxt   = CNT_W'(1);
                    w_hi_nxt    = CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!bus.enable || w_to) begin
            w_state_nxt = IDLE;
            w_per_nxt   = '0;
            w_hi_nxt    = '0;
            w_pub       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt_per <= '0;
            r_cnt_hi  <= '0;
            r_age     <= '0;
            r_lvl_d   <= 1'b0;
            r_period  <= '0;
            r_high    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt_per <= w_per_nxt;
            r_cnt_hi  <= w_hi_nxt;
            r_age     <= w_age_nxt;
            r_lvl_d   <= w_lvl;
            r_valid   <= w_pub;
            if (w_pub) begin
                r_period <= r_cnt_per;
                r_high   <= r_cnt_hi;
            end
            r_timeout <= (!bus.enable || w_pub) ? 1'b0 : w_to ? 1'b1 : r_timeout;
        end
    end

    assign bus.pwm_level  = w_lvl;
    assign bus.period     = r_period;
    assign bus.high_time  = r_high;
    assign bus.meas_valid = r_valid;
    assign bus.timeout    = r_timeout;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench; expected measurements are queued as PWM pulses are driven.
module tb_pwm_capture;
    logic        clk = 1'b0;
    logic        rst_n;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_valid_cyc = 0;
    logic [31:0] q[$];
    logic [31:0] e;
    logic [15:0] last_per = '0;
    logic [15:0] last_hi = '0;
    logic        prev_valid = 1'b0;
    logic        armed = 1'b0;
    int          prev_h = 0;
    int          prev_l = 0;

    pwm_capture_if #(.CNT_W(16)) bus ();
    pwm_capture #(.CNT_W(16), .TIMEOUT(16'd200), .GLITCH_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_prev();
        if (armed) q.push_back({16'(prev_h + prev_l), 16'(prev_h)});
    endtask

    task automatic drive_pulse(input int h, input int l);
        push_prev();
        armed  = 1'b1;
        prev_h = h;
        prev_l = l;
        bus.pwm_in = 1'b1;
        repeat (h) step();
        bus.pwm_in = 1'b0;
        repeat (l) step();
    endtask

    // high h, low l1, then a pulse of g cycles followed by low l2
    task automatic drive_glitch(input int h, input int l1, input int g, input int l2);
        push_prev();
        armed = 1'b1;
        bus.pwm_in = 1'b1;
        repeat (h) step();
        bus.pwm_in = 1'b0;
        repeat (l1) step();
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        if (g >= 3) begin
            q.push_back({16'(h + l1), 16'(h)});
            prev_h = g;
            prev_l = l2;
        end else begin
            prev_h = h;
            prev_l = l1 + g + l2;
        end
`else
        q.push_back({16'(h + l1), 16'(h)});
        prev_h = g;
        prev_l = l2;
`endif
        bus.pwm_in = 1'b1;
        repeat (g) step();
        bus.pwm_in = 1'b0;
        repeat (l2) step();
    endtask

    always @(negedge clk) begin
        if (bus.meas_valid) begin
            if (prev_valid) chk("valid_width", 32'd1, 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_publish", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("period", 32'(bus.period), 32'(e[31:16]));
                chk("high_time", 32'(bus.high_time), 32'(e[15:0]));
                last_per = e[31:16];
                last_hi  = e[15:0];
            end
            last_valid_cyc = cyc;
        end
        prev_valid = bus.meas_valid;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.pwm_in = 1'b0;
        repeat (3) step();
        chk("rst_period", 32'(bus.period), 0);
        chk("rst_high", 32'(bus.high_time), 0);
        chk("rst_valid", 32'(bus.meas_valid), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        chk("rst_level", 32'(bus.pwm_level), 0);
        rst_n = 1'b1;
        repeat (5) step();

        repeat (4) drive_pulse(30, 70);
        repeat (3) drive_pulse(75, 25);
        chk("duty_q_empty", 32'(q.size()), 0);

        push_prev();
        armed = 1'b0;
        bus.pwm_in = 1'b1;
        for (int i = 0; i < 400 && !bus.timeout; i++) @(negedge clk);
        chk("to_set", 32'(bus.timeout), 1);
        chk("to_delay", 32'(cyc - last_valid_cyc), 200);
        chk("to_period", 32'(bus.period), 32'(last_per));
        chk("to_high", 32'(bus.high_time), 32'(last_hi));
        step();
        bus.pwm_in = 1'b0;
        repeat (20) step();
        drive_pulse(10, 10);
        chk("to_hold", 32'(bus.timeout), 1);
        drive_pulse(10, 10);
        chk("to_clear", 32'(bus.timeout), 0);
        drive_pulse(10, 10);

        push_prev();
        bus.pwm_in = 1'b1;
        repeat (10) step();
        chk("level_high", 32'(bus.pwm_level), 1);
        rst_n = 1'b0;
        bus.pwm_in = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_period", 32'(bus.period), 0);
        chk("mid_rst_high", 32'(bus.high_time), 0);
        chk("mid_rst_valid", 32'(bus.meas_valid), 0);
        chk("mid_rst_timeout", 32'(bus.timeout), 0);
        chk("mid_rst_level", 32'(bus.pwm_level), 0);
        armed = 1'b0;
        repeat (20) step();
        repeat (3) drive_pulse(40, 60);

        push_prev();
        bus.pwm_in = 1'b1;
        repeat (30) step();
        bus.pwm_in = 1'b0;
        repeat (10) step();
        bus.enable = 1'b0;
        repeat (5) step();
        chk("en_timeout", 32'(bus.timeout), 0);
        chk("en_valid", 32'(bus.meas_valid), 0);
        chk("en_period_hold", 32'(bus.period), 32'(last_per));
        bus.enable = 1'b1;
        armed = 1'b0;
        repeat (55) step();
        repeat (3) drive_pulse(20, 30);

        drive_glitch(50, 20, 2, 28);
        drive_glitch(50, 20, 2, 28);
        drive_glitch(50, 20, 3, 27);
        repeat (2) drive_pulse(50, 50);
        repeat (10) step();
        chk("end_q_empty", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
